lattice_boundary_scanner: RTL and testbench
===========================================

Name: lattice_boundary_scanner

Overview:
Parametrised successor to the wall detector. Owns its own raster scan over an NX x NY D2Q9 lattice instead of taking externally driven x/y. For every node it emits coordinates, linear address, boundary flags and west/east neighbour addresses, with selectable periodic-X mode and moving-lid enable. Feeds the collide/stream pipeline through a valid/ready handshake and tracks completed sweeps.

Parameters:
NX, 16, lattice width in nodes (>=2)
NY, 16, lattice height in nodes (>=2)
XW, $clog2(NX), x coordinate width
YW, $clog2(NY), y coordinate width
AW, $clog2(NX*NY), linear address width
SW, 16, sweep counter width

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Clear  in  1  synchronous abort: return to IDLE, keep Sweep_Count
Start  in  1  begin a sweep; sampled only in IDLE
Periodic_X  in  1  mode: left/right edges wrap; sampled at Start
Lid_En  in  1  top row is a moving lid (else stationary top wall); sampled at Start
Auto_Restart  in  1  chain sweeps back-to-back; sampled at Start and at each sweep end
Out_Ready  in  1  downstream accepts current node
Out_Valid  out  1  node outputs valid
X  out  XW  node x
Y  out  YW  node y
Addr  out  AW  Y*NX+X
LID  out  1  y==NY-1 and lid enabled
TOP_WALL  out  1  y==NY-1 and lid disabled
BOTTOM_WALL  out  1  y==0
LEFT_WALL  out  1  x==0 and not periodic
RIGHT_WALL  out  1  x==NX-1 and not periodic
West_Addr  out  AW  address of x-1 neighbour (same row)
East_Addr  out  AW  address of x+1 neighbour (same row)
Busy  out  1  FSM in SCAN
Done  out  1  one-cycle pulse after final node of a sweep is accepted
Sweep_Count  out  SW  completed sweeps, wraps modulo 2^SW

Behaviour:
- Reset: FSM=IDLE; Out_Valid, Busy, Done, all flags =0; X, Y, Addr, West_Addr, East_Addr, Sweep_Count =0; latched modes =0.
- FSM states IDLE, SCAN.
- IDLE + Start: latch modes, X=Y=0, enter SCAN. Out_Valid=1 on the next cycle (1-cycle latency). Start is ignored in SCAN.
- SCAN: a handshake is Out_Valid&&Out_Ready. All outputs are registered and held stable while Out_Valid&&!Out_Ready.
- Advance on handshake in raster order, x fastest: X++ and, at X==NX-1, X=0 and Y++.
- Last node (NX-1, NY-1) handshake:
  - Sweep_Count++ and Done=1 on the next cycle, for one cycle.
  - If Auto_Restart=1: stay in SCAN with X=Y=0 and Out_Valid kept 1 (no bubble); re-latch modes.
  - Otherwise go to IDLE with Out_Valid=0.
- Flags are a pure function of the registered X/Y and the latched modes, updated with X/Y. Corners assert two flags; e.g. (0,0) non-periodic gives LEFT_WALL and BOTTOM_WALL.
- Neighbours in periodic mode: West of x=0 is (NX-1,y); East of x=NX-1 is (0,y).
- Neighbours in non-periodic mode: the wall-side neighbour equals the node's own Addr (bounce-back clamp).
- Interior nodes: West_Addr=Addr-1, East_Addr=Addr+1.
- Arithmetic: Addr is computed from X/Y or held as an incrementing counter, and must always equal Y*NX+X for non-power-of-two NX. No overflow past NX*NY-1.
- Clear (any state): IDLE, Out_Valid=0, Done=0, X=Y=0 on the next edge; Sweep_Count is not incremented. Clear has priority over Start and over a same-cycle final handshake.
- Reset mid-sweep: immediate return to reset values.

Decomposition:
- Package lbm_pkg: scan_state_t enum {IDLE, SCAN}; boundary_flags_t struct (lid, top, bottom, left, right); a helper function computing linear address from x, y, NX.
- One natural sub-module, lattice_coord_counter: X/Y/Addr counters with enable, clear, and last-node flag.
- Flag and neighbour logic stays in the top module.

Test Plan:
- Default 16x16, Start, Out_Ready=1: node (13,3) has all flags 0, Addr=61, West=60, East=62. Node (15,2) has RIGHT_WALL=1, Addr=47, East_Addr=47. Done pulses once after 256 handshakes; Sweep_Count=1.
- Node (7,15) with Lid_En=1 gives LID=1, TOP_WALL=0. Re-run with Lid_En=0: LID=0, TOP_WALL=1.
- NX=5, NY=3, Periodic_X=1: at (0,1), LEFT_WALL=0, Addr=5, West_Addr=9. At (4,1), East_Addr=5. Non-periodic (0,0) gives LEFT_WALL=1, BOTTOM_WALL=1, West_Addr=0.
- Out_Ready held low 4 cycles at (3,2): all outputs stable across those cycles; the next handshake presents (4,2). No node is skipped or duplicated over the full sweep.
- Auto_Restart=1, two sweeps: node (0,0) appears the cycle after (NX-1,NY-1) with no Out_Valid gap. Done pulses twice; Sweep_Count=2. Start during SCAN has no effect.
- Clear asserted at node (2,1): next cycle Out_Valid=0, Busy=0, Sweep_Count unchanged. Reset mid-sweep: all outputs 0 asynchronously.

Source files
------------

// File: rtl/lattice_boundary_scanner_pkg.sv
// lbm_pkg: shared types and helpers for the lattice boundary scanner.
//   scan_state_t     - scanner FSM states (IDLE, SCAN)
//   boundary_flags_t - per-node boundary classification bits
//   lin_addr()       - row-major linear address y*nx + x
package lbm_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic lid;
    logic top;
    logic bottom;
    logic left;
    logic right;
  } boundary_flags_t;

  function automatic int unsigned lin_addr(input int unsigned x,
                                           input int unsigned y,
                                           input int unsigned nx);
    return (y * nx) + x;
  endfunction

endpackage

// File: rtl/lattice_boundary_scanner_if.sv
// Bus between the lattice scanner and the collide/stream pipeline.
//   Control (into scanner): Clear, Start, Periodic_X, Lid_En, Auto_Restart
//   Handshake:              Out_Valid (scanner), Out_Ready (consumer)
//   Node payload:           X, Y, Addr, flags, West_Addr, East_Addr
//   Status:                 Busy, Done, Sweep_Count
// master = the scanner, slave = the controller/consumer side.
interface lattice_boundary_scanner_if #(
  parameter int XW = 4,
  parameter int YW = 4,
  parameter int AW = 8,
  parameter int SW = 16
) ();
  logic          Clear;
  logic          Start;
  logic          Periodic_X;
  logic          Lid_En;
  logic          Auto_Restart;
  logic          Out_Ready;
  logic          Out_Valid;
  logic [XW-1:0] X;
  logic [YW-1:0] Y;
  logic [AW-1:0] Addr;
  logic          LID;
  logic          TOP_WALL;
  logic          BOTTOM_WALL;
  logic          LEFT_WALL;
  logic          RIGHT_WALL;
  logic [AW-1:0] West_Addr;
  logic [AW-1:0] East_Addr;
  logic          Busy;
  logic          Done;
  logic [SW-1:0] Sweep_Count;

  modport master (
    input  Clear, Start, Periodic_X, Lid_En, Auto_Restart, Out_Ready,
    output Out_Valid, X, Y, Addr, LID, TOP_WALL, BOTTOM_WALL, LEFT_WALL,
           RIGHT_WALL, West_Addr, East_Addr, Busy, Done, Sweep_Count
  );

  modport slave (
    output Clear, Start, Periodic_X, Lid_En, Auto_Restart, Out_Ready,
    input  Out_Valid, X, Y, Addr, LID, TOP_WALL, BOTTOM_WALL, LEFT_WALL,
           RIGHT_WALL, West_Addr, East_Addr, Busy, Done, Sweep_Count
  );
endinterface

// File: rtl/lattice_boundary_scanner_coord_counter.sv
// lattice_coord_counter: raster-order X/Y/Addr counter, x fastest.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : synchronous return to (0,0)
//   en_i     : advance one node
//   x_o/y_o  : current coordinates
//   addr_o   : current linear address (kept as its own counter, always y*NX+x)
//   last_o   : current node is (NX-1, NY-1)
module lattice_coord_counter
  import lbm_pkg::*;
#(
  parameter int NX = 16,
  parameter int NY = 16,
  parameter int XW = $clog2(NX),
  parameter int YW = $clog2(NY),
  parameter int AW = $clog2(NX * NY)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  localparam logic [XW-1:0] X_MAX = XW'(NX - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(NY - 1);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);
  localparam logic [AW-1:0] A_ONE = AW'(1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          last_s;

  assign last_s = (x_q == X_MAX) && (y_q == Y_MAX);

  // Next-state: raster advance; the address counter wraps together with x/y
  // so it never runs past NX*NY-1.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clr_i) begin
      x_d    = {XW{1'b0}};
      y_d    = {YW{1'b0}};
      addr_d = {AW{1'b0}};
    end else if (en_i) begin
      if (last_s) begin
        x_d    = {XW{1'b0}};
        y_d    = {YW{1'b0}};
        addr_d = {AW{1'b0}};
      end else if (x_q == X_MAX) begin
        x_d    = {XW{1'b0}};
        y_d    = y_q + Y_ONE;
        addr_d = addr_q + A_ONE;
      end else begin
        x_d    = x_q + X_ONE;
        addr_d = addr_q + A_ONE;
      end
    end else begin
      x_d    = x_q;
      y_d    = y_q;
      addr_d = addr_q;
    end
  end

  // Coordinate registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= {XW{1'b0}};
      y_q    <= {YW{1'b0}};
      addr_q <= {AW{1'b0}};
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign addr_o = addr_q;
  assign last_o = last_s;

endmodule

// File: rtl/lattice_boundary_scanner.sv
// lattice_boundary_scanner: self-driven raster scan over an NX x NY D2Q9
// lattice. Per node it presents coordinates, linear address, boundary flags
// and west/east neighbour addresses on a valid/ready bus, and counts sweeps.
//   Clk, Reset : clock, asynchronous active-high reset
//   bus        : lattice_boundary_scanner_if master (control, handshake,
//                node payload, Busy/Done/Sweep_Count)
// Flags and neighbour addresses are forced to zero whenever no node is
// presented, so the idle bus matches the reset values.
module lattice_boundary_scanner
  import lbm_pkg::*;
#(
  parameter int NX = 16,
  parameter int NY = 16,
  parameter int XW = $clog2(NX),
  parameter int YW = $clog2(NY),
  parameter int AW = $clog2(NX * NY),
  parameter int SW = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  lattice_boundary_scanner_if.master bus
);

  localparam logic [XW-1:0] X_MAX    = XW'(NX - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(NY - 1);
  localparam logic [AW-1:0] A_ONE    = AW'(1);
  localparam logic [SW-1:0] S_ONE    = SW'(1);
  // Distance from the first to the last node of a row.
  localparam logic [AW-1:0] ROW_SPAN = AW'(lin_addr(NX - 1, 0, NX));

  scan_state_t     state_q;
  logic            periodic_q;
  logic            lid_q;
  logic            done_q;
  logic [SW-1:0]   sweep_q;

  logic            valid_s;
  logic            hs_s;
  logic            cnt_clr_s;
  logic            last_s;
  logic [XW-1:0]   x_s;
  logic [YW-1:0]   y_s;
  logic [AW-1:0]   addr_s;
  logic [AW-1:0]   west_s;
  logic [AW-1:0]   east_s;
  boundary_flags_t flags_s;

  assign valid_s   = (state_q == SCAN);
  assign hs_s      = valid_s && bus.Out_Ready;
  // Counter also clears on a sweep start so a stale position can never leak.
  assign cnt_clr_s = bus.Clear || ((state_q == IDLE) && bus.Start);

  lattice_coord_counter #(
    .NX (NX),
    .NY (NY),
    .XW (XW),
    .YW (YW),
    .AW (AW)
  ) u_coord (
    .clk    (Clk),
    .rst    (Reset),
    .clr_i  (cnt_clr_s),
    .en_i   (hs_s),
    .x_o    (x_s),
    .y_o    (y_s),
    .addr_o (addr_s),
    .last_o (last_s)
  );

  // Scan FSM: mode latching, sweep counting and the Done pulse. Clear wins
  // over Start and over a simultaneous final handshake.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      periodic_q <= 1'b0;
      lid_q      <= 1'b0;
      done_q     <= 1'b0;
      sweep_q    <= {SW{1'b0}};
    end else if (bus.Clear) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            periodic_q <= bus.Periodic_X;
            lid_q      <= bus.Lid_En;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          done_q <= 1'b0;
          if (bus.Out_Ready && last_s) begin
            sweep_q <= sweep_q + S_ONE;
            done_q  <= 1'b1;
            if (bus.Auto_Restart) begin
              periodic_q <= bus.Periodic_X;
              lid_q      <= bus.Lid_En;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Boundary flags and neighbour addresses from the registered position and
  // latched modes. Non-periodic wall-side neighbours clamp to the node itself.
  always_comb begin
    flags_s = 5'b00000;
    west_s  = {AW{1'b0}};
    east_s  = {AW{1'b0}};
    if (valid_s) begin
      flags_s.lid    = (y_s == Y_MAX) && lid_q;
      flags_s.top    = (y_s == Y_MAX) && !lid_q;
      flags_s.bottom = (y_s == {YW{1'b0}});
      flags_s.left   = (x_s == {XW{1'b0}}) && !periodic_q;
      flags_s.right  = (x_s == X_MAX) && !periodic_q;
      if (x_s == {XW{1'b0}}) begin
        west_s = periodic_q ? (addr_s + ROW_SPAN) : addr_s;
      end else begin
        west_s = addr_s - A_ONE;
      end
      if (x_s == X_MAX) begin
        east_s = periodic_q ? (addr_s - ROW_SPAN) : addr_s;
      end else begin
        east_s = addr_s + A_ONE;
      end
    end else begin
      flags_s = 5'b00000;
      west_s  = {AW{1'b0}};
      east_s  = {AW{1'b0}};
    end
  end

  assign bus.Out_Valid   = valid_s;
  assign bus.Busy        = valid_s;
  assign bus.Done        = done_q;
  assign bus.Sweep_Count = sweep_q;
  assign bus.X           = x_s;
  assign bus.Y           = y_s;
  assign bus.Addr        = addr_s;
  assign bus.LID         = flags_s.lid;
  assign bus.TOP_WALL    = flags_s.top;
  assign bus.BOTTOM_WALL = flags_s.bottom;
  assign bus.LEFT_WALL   = flags_s.left;
  assign bus.RIGHT_WALL  = flags_s.right;
  assign bus.West_Addr   = west_s;
  assign bus.East_Addr   = east_s;

endmodule

// File: tb/tb_lattice_boundary_scanner.sv
// Testbench: two scanners (16x16 and 5x3) driven by directed then random
// stimulus, compared every cycle against a node-index reference model.
module tb_lattice_boundary_scanner;

  logic clk;
  logic rst;

  lattice_boundary_scanner_if #(.XW(4), .YW(4), .AW(8), .SW(16)) bus_a ();
  lattice_boundary_scanner_if #(.XW(3), .YW(2), .AW(4), .SW(16)) bus_b ();

  lattice_boundary_scanner #(.NX(16), .NY(16)) dut_a (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus_a.master)
  );

  lattice_boundary_scanner #(.NX(5), .NY(3)) dut_b (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Lattice sizes per scanner.
  int nx_c [2];
  int ny_c [2];

  // Reference model state: one node index per scanner.
  bit busy_m [2];
  int n_m    [2];
  int sw_m   [2];
  bit done_m [2];
  bit per_m  [2];
  bit lid_m  [2];

  // Stimulus for the next edge.
  bit clr_v [2];
  bit st_v  [2];
  bit per_v [2];
  bit lid_v [2];
  bit ar_v  [2];
  bit rdy_v [2];

  logic [31:0] obs [14];
  logic [31:0] expv[14];
  string       names[14];
  int          hold_cnt;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic apply_inputs();
    bus_a.Clear = clr_v[0]; bus_a.Start = st_v[0]; bus_a.Periodic_X = per_v[0];
    bus_a.Lid_En = lid_v[0]; bus_a.Auto_Restart = ar_v[0]; bus_a.Out_Ready = rdy_v[0];
    bus_b.Clear = clr_v[1]; bus_b.Start = st_v[1]; bus_b.Periodic_X = per_v[1];
    bus_b.Lid_En = lid_v[1]; bus_b.Auto_Restart = ar_v[1]; bus_b.Out_Ready = rdy_v[1];
  endtask

  task automatic sample(input int d);
    if (d == 0) begin
      obs[0] = 32'(bus_a.Out_Valid); obs[1] = 32'(bus_a.Busy); obs[2] = 32'(bus_a.Done);
      obs[3] = 32'(bus_a.Sweep_Count); obs[4] = 32'(bus_a.X); obs[5] = 32'(bus_a.Y);
      obs[6] = 32'(bus_a.Addr); obs[7] = 32'(bus_a.LID); obs[8] = 32'(bus_a.TOP_WALL);
      obs[9] = 32'(bus_a.BOTTOM_WALL); obs[10] = 32'(bus_a.LEFT_WALL);
      obs[11] = 32'(bus_a.RIGHT_WALL); obs[12] = 32'(bus_a.West_Addr);
      obs[13] = 32'(bus_a.East_Addr);
    end else begin
      obs[0] = 32'(bus_b.Out_Valid); obs[1] = 32'(bus_b.Busy); obs[2] = 32'(bus_b.Done);
      obs[3] = 32'(bus_b.Sweep_Count); obs[4] = 32'(bus_b.X); obs[5] = 32'(bus_b.Y);
      obs[6] = 32'(bus_b.Addr); obs[7] = 32'(bus_b.LID); obs[8] = 32'(bus_b.TOP_WALL);
      obs[9] = 32'(bus_b.BOTTOM_WALL); obs[10] = 32'(bus_b.LEFT_WALL);
      obs[11] = 32'(bus_b.RIGHT_WALL); obs[12] = 32'(bus_b.West_Addr);
      obs[13] = 32'(bus_b.East_Addr);
    end
  endtask

  // Expected bus contents derived from the node index and latched modes.
  task automatic model_out(input int d);
    int nx, ny, n, x, y, w, e;
    bit v;
    nx = nx_c[d]; ny = ny_c[d]; n = n_m[d]; v = busy_m[d];
    x = n % nx; y = n / nx;
    if (x == 0) w = per_m[d] ? (y * nx + nx - 1) : n;
    else        w = n - 1;
    if (x == nx - 1) e = per_m[d] ? (y * nx) : n;
    else             e = n + 1;
    expv[0]  = 32'(v);
    expv[1]  = 32'(v);
    expv[2]  = 32'(done_m[d]);
    expv[3]  = 32'(sw_m[d] % 65536);
    expv[4]  = 32'(x);
    expv[5]  = 32'(y);
    expv[6]  = 32'(n);
    expv[7]  = 32'(v && (y == ny - 1) && lid_m[d]);
    expv[8]  = 32'(v && (y == ny - 1) && !lid_m[d]);
    expv[9]  = 32'(v && (y == 0));
    expv[10] = 32'(v && (x == 0) && !per_m[d]);
    expv[11] = 32'(v && (x == nx - 1) && !per_m[d]);
    expv[12] = v ? 32'(w) : 32'd0;
    expv[13] = v ? 32'(e) : 32'd0;
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      sample(d);
      model_out(d);
      for (int i = 0; i < 14; i++)
        chk_val($sformatf("d%0d.%s", d, names[i]), obs[i], expv[i]);
      // Fixed spot values for known nodes.
      if (d == 0 && obs[0] == 32'd1 && obs[4] == 32'd13 && obs[5] == 32'd3) begin
        chk_val("a13_3.addr", obs[6], 32'd61);
        chk_val("a13_3.west", obs[12], 32'd60);
        chk_val("a13_3.east", obs[13], 32'd62);
        chk_val("a13_3.flags", obs[7] | obs[8] | obs[9] | obs[10] | obs[11], 32'd0);
      end
      if (d == 0 && obs[0] == 32'd1 && obs[4] == 32'd15 && obs[5] == 32'd2 && !per_m[0]) begin
        chk_val("a15_2.right", obs[11], 32'd1);
        chk_val("a15_2.addr", obs[6], 32'd47);
        chk_val("a15_2.east", obs[13], 32'd47);
      end
      if (d == 1 && obs[0] == 32'd1 && per_m[1] && obs[5] == 32'd1) begin
        if (obs[4] == 32'd0) begin
          chk_val("b0_1.left", obs[10], 32'd0);
          chk_val("b0_1.addr", obs[6], 32'd5);
          chk_val("b0_1.west", obs[12], 32'd9);
        end
        if (obs[4] == 32'd4) chk_val("b4_1.east", obs[13], 32'd5);
      end
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      busy_m[d] = 1'b0; n_m[d] = 0; sw_m[d] = 0; done_m[d] = 1'b0;
      per_m[d] = 1'b0; lid_m[d] = 1'b0;
    end
  endtask

  // One clock edge of scanner behaviour, at node-index level.
  task automatic model_step(input int d);
    done_m[d] = 1'b0;
    if (clr_v[d]) begin
      busy_m[d] = 1'b0;
      n_m[d]    = 0;
    end else if (!busy_m[d]) begin
      if (st_v[d]) begin
        busy_m[d] = 1'b1; n_m[d] = 0; per_m[d] = per_v[d]; lid_m[d] = lid_v[d];
      end
    end else if (rdy_v[d]) begin
      if (n_m[d] == nx_c[d] * ny_c[d] - 1) begin
        sw_m[d]++;
        done_m[d] = 1'b1;
        n_m[d]    = 0;
        if (ar_v[d]) begin
          per_m[d] = per_v[d]; lid_m[d] = lid_v[d];
        end else begin
          busy_m[d] = 1'b0;
        end
      end else begin
        n_m[d]++;
      end
    end
  endtask

  task automatic pick_stimulus(input int cyc);
    if (cyc < 1400) begin
      // Scanner A: Lid_En sweep then stationary-lid sweeps, one stall at (3,2),
      // Start held high throughout, Clear mid-sweep.
      st_v[0] = 1'b1; per_v[0] = 1'b0; ar_v[0] = 1'b0;
      lid_v[0] = (cyc < 200);
      clr_v[0] = (cyc == 900);
      if (busy_m[0] && n_m[0] == 35 && hold_cnt < 4) begin
        rdy_v[0] = 1'b0;
        hold_cnt++;
      end else begin
        rdy_v[0] = 1'b1;
        if (n_m[0] != 35) hold_cnt = 0;
      end
      // Scanner B: back-to-back periodic then non-periodic sweeps.
      st_v[1] = 1'b1; rdy_v[1] = 1'b1; lid_v[1] = 1'b1; clr_v[1] = 1'b0;
      per_v[1] = (cyc < 700);
      ar_v[1] = (cyc < 1300);
    end else begin
      for (int d = 0; d < 2; d++) begin
        st_v[d]  = ($urandom_range(0, 3) == 0);
        rdy_v[d] = ($urandom_range(0, 3) != 0);
        per_v[d] = 1'($urandom_range(0, 1));
        lid_v[d] = 1'($urandom_range(0, 1));
        ar_v[d]  = 1'($urandom_range(0, 1));
        clr_v[d] = ($urandom_range(0, 999) == 0);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; hold_cnt = 0;
    nx_c[0] = 16; ny_c[0] = 16;
    nx_c[1] = 5;  ny_c[1] = 3;
    names = '{"valid", "busy", "done", "sweeps", "x", "y", "addr", "lid", "top",
              "bottom", "left", "right", "west", "east"};
    for (int d = 0; d < 2; d++) begin
      clr_v[d] = 1'b0; st_v[d] = 1'b0; per_v[d] = 1'b0;
      lid_v[d] = 1'b0; ar_v[d] = 1'b0; rdy_v[d] = 1'b0;
    end
    apply_inputs();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    for (int cyc = 0; cyc < 5400; cyc++) begin
      pick_stimulus(cyc);
      apply_inputs();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      check_all();
      if (cyc == 3000) begin
        // Asynchronous reset between edges; outputs must clear before any edge.
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
          clr_v[d] = 1'b0; st_v[d] = 1'b0; rdy_v[d] = 1'b0;
        end
        apply_inputs();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
